// File: rtl/pcs_tx_gearbox_if.sv
// Block handshake between the 64b/66b encoder (master) and the TX gearbox (slave).
// One 66-bit block moves per cycle in which block_valid and block_ready are both high.
interface pcs_tx_gearbox_if;
    logic [1:0]  block_hdr;
    logic [63:0] block_data;
    logic        block_valid;
    logic        block_ready;

    modport master (
        output block_hdr,
        output block_data,
        output block_valid,
        input  block_ready
    );

    modport slave (
        input  block_hdr,
        input  block_data,
        input  block_valid,
        output block_ready
    );
endinterface

// File: rtl/pcs_tx_gearbox.sv
// 66b -> DATA_WIDTH TX gearbox feeding a GTY with its internal gearbox disabled.
// It emits one word every cycle and backpressures the encoder so that the output never stalls.
module pcs_tx_gearbox #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    pcs_tx_gearbox_if.slave        blk_if,
    output logic [DATA_WIDTH-1:0]  o_tx_data,
    output logic                   o_underflow,
    output logic [CNT_WIDTH-1:0]   o_underflow_cnt
);
    localparam int unsigned BLK_W  = 66;
    localparam int unsigned BUF_W  = DATA_WIDTH + BLK_W;
    localparam int unsigned FILL_W = $clog2(BUF_W + 1);

    generate
        if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
            $error("pcs_tx_gearbox: DATA_WIDTH must be 32 or 64");
        end
    endgenerate

    logic [BUF_W-1:0]      r_buf;
    logic [FILL_W-1:0]     r_fill;
    logic                  r_primed;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_drain;
    logic                  w_underflow;
    logic [BLK_W-1:0]      w_block;
    logic [BUF_W-1:0]      w_rem_buf;
    logic [BUF_W-1:0]      w_next_buf;
    logic [FILL_W-1:0]     w_rem;
    logic [FILL_W-1:0]     w_next_fill;
    logic [DATA_WIDTH-1:0] w_word;
    logic [DATA_WIDTH-1:0] w_mask;

    // Ready depends on the fill level only, so it never combinationally loops on valid.
    assign w_ready            = r_fill < FILL_W'(2 * DATA_WIDTH);
    assign w_accept           = blk_if.block_valid & w_ready;
    assign blk_if.block_ready = w_ready;

    always_comb begin
        w_block     = {blk_if.block_data, blk_if.block_hdr};
        w_drain     = r_fill >= FILL_W'(DATA_WIDTH);
        w_mask      = ~({DATA_WIDTH{1'b1}} << r_fill);
        w_word      = r_buf[DATA_WIDTH-1:0];
        w_rem_buf   = r_buf >> DATA_WIDTH;
        w_rem       = r_fill - FILL_W'(DATA_WIDTH);
        w_underflow = 1'b0;
        if (!w_drain) begin
            // Short word: pad above the valid bits and restart the buffer empty.
            w_word      = r_buf[DATA_WIDTH-1:0] & w_mask;
            w_rem_buf   = '0;
            w_rem       = '0;
            w_underflow = r_primed;
        end
        w_next_buf  = w_rem_buf | (w_accept ? (BUF_W'(w_block) << w_rem) : '0);
        w_next_fill = w_rem + (w_accept ? FILL_W'(BLK_W) : '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_buf           <= '0;
            r_fill          <= '0;
            r_primed        <= 1'b0;
            o_tx_data       <= '0;
            o_underflow     <= 1'b0;
            o_underflow_cnt <= '0;
        end else begin
            r_buf       <= w_next_buf;
            r_fill      <= w_next_fill;
            r_primed    <= r_primed | w_accept;
            o_tx_data   <= w_word;
            o_underflow <= w_underflow;
            if (w_underflow && (o_underflow_cnt != {CNT_WIDTH{1'b1}})) begin
                o_underflow_cnt <= o_underflow_cnt + CNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_pcs_tx_gearbox.sv
// Bench for pcs_tx_gearbox: a 64-bit and a 32-bit instance are checked every cycle against a
// bit-queue model of the transmitted serial stream, plus directed vectors and corner sequences.
module tb_pcs_tx_gearbox;
    localparam int unsigned CW64 = 16;
    localparam int unsigned CW32 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst     [2];
    logic [1:0]  s_hdr   [2];
    logic [63:0] s_data  [2];
    logic        s_valid [2];

    logic [63:0]     tx64;
    logic [31:0]     tx32;
    logic            uf64, uf32;
    logic [CW64-1:0] cnt64;
    logic [CW32-1:0] cnt32;

    pcs_tx_gearbox_if if64();
    pcs_tx_gearbox_if if32();

    assign if64.block_hdr   = s_hdr[0];
    assign if64.block_data  = s_data[0];
    assign if64.block_valid = s_valid[0];
    assign if32.block_hdr   = s_hdr[1];
    assign if32.block_data  = s_data[1];
    assign if32.block_valid = s_valid[1];

    pcs_tx_gearbox #(.DATA_WIDTH(64), .CNT_WIDTH(CW64)) dut64 (
        .i_clk(clk), .i_reset(rst[0]), .blk_if(if64),
        .o_tx_data(tx64), .o_underflow(uf64), .o_underflow_cnt(cnt64)
    );
    pcs_tx_gearbox #(.DATA_WIDTH(32), .CNT_WIDTH(CW32)) dut32 (
        .i_clk(clk), .i_reset(rst[1]), .blk_if(if32),
        .o_tx_data(tx32), .o_underflow(uf32), .o_underflow_cnt(cnt32)
    );

    // Reference model: queue of bits waiting to go out on the serial line.
    int unsigned dw   [2] = '{64, 32};
    int unsigned cmax [2] = '{65535, 15};
    bit          mq   [2][$];
    bit          m_primed [2];
    logic [63:0] e_data [2];
    bit          e_uf   [2];
    int unsigned e_cnt  [2];
    bit          e_full [2];
    bit          last_acc [2];
    logic        act_rdy  [2];
    bit          txs [2][$];
    bit          rxs [2][$];
    bit          rec_on = 1'b0;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    typedef struct {
        logic [1:0]  hdr;
        logic [63:0] data;
        logic [63:0] exp64;
        logic [31:0] exp32_lo;
        logic [31:0] exp32_hi;
    } vec_t;
    vec_t vecs [4];

    function automatic logic [63:0] get_tx(input int k);
        if (k == 0) return tx64;
        return {32'd0, tx32};
    endfunction

    function automatic logic [63:0] get_uf(input int k);
        if (k == 0) return 64'(uf64);
        return 64'(uf32);
    endfunction

    function automatic logic [63:0] get_cnt(input int k);
        if (k == 0) return 64'(cnt64);
        return 64'(cnt32);
    endfunction

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dw=%0d cyc=%0d got=%h want=%h", nm, dw[k], cyc, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s cyc=%0d bound expired", nm, cyc);
    endtask

    // One clock: check ready, advance the model, clock, then check registered outputs.
    task automatic cycle();
        logic        rdy_m;
        logic [63:0] w;
        logic [63:0] t;
        int          n;
        for (int k = 0; k < 2; k++) begin
            rdy_m      = mq[k].size() < int'(2 * dw[k]);
            act_rdy[k] = (k == 0) ? if64.block_ready : if32.block_ready;
            chk("ready", k, 64'(act_rdy[k]), 64'(rdy_m));
            last_acc[k] = s_valid[k] && rdy_m && !rst[k];
            if (rst[k]) begin
                mq[k].delete();
                m_primed[k] = 1'b0;
                e_data[k]   = '0;
                e_uf[k]     = 1'b0;
                e_cnt[k]    = 0;
                e_full[k]   = 1'b0;
            end else begin
                w         = '0;
                e_full[k] = mq[k].size() >= int'(dw[k]);
                n         = e_full[k] ? int'(dw[k]) : mq[k].size();
                for (int i = 0; i < n; i++) w[i] = mq[k].pop_front();
                e_uf[k] = !e_full[k] && m_primed[k];
                if (e_uf[k] && e_cnt[k] != cmax[k]) e_cnt[k]++;
                e_data[k] = w;
                if (last_acc[k]) begin
                    mq[k].push_back(s_hdr[k][0]);
                    mq[k].push_back(s_hdr[k][1]);
                    for (int i = 0; i < 64; i++) mq[k].push_back(s_data[k][i]);
                    if (rec_on) begin
                        txs[k].push_back(s_hdr[k][0]);
                        txs[k].push_back(s_hdr[k][1]);
                        for (int i = 0; i < 64; i++) txs[k].push_back(s_data[k][i]);
                    end
                    m_primed[k] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            chk("tx_data", k, get_tx(k), e_data[k]);
            chk("underflow", k, get_uf(k), 64'(e_uf[k]));
            chk("uf_cnt", k, get_cnt(k), 64'(e_cnt[k]));
            if (rec_on && e_full[k]) begin
                t = get_tx(k);
                for (int i = 0; i < int'(dw[k]); i++) rxs[k].push_back(t[i]);
            end
        end
    endtask

    // Source: holds an unaccepted block, otherwise offers a fresh random one when asked.
    task automatic src_next(input int k, input bit want);
        if (s_valid[k] && !last_acc[k]) return;
        s_valid[k] = want;
        if (want) begin
            s_hdr[k]  = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
            s_data[k] = {$urandom, $urandom};
        end
    endtask

    task automatic do_reset();
        rst[0] = 1'b1; rst[1] = 1'b1;
        s_valid[0] = 1'b0; s_valid[1] = 1'b0;
        cycle();
        rst[0] = 1'b0; rst[1] = 1'b0;
    endtask

    initial begin
        int          low64, adj, acc32, uf_seen, n_uf, mism, guard, nacc;
        bit          prev_low;
        logic [1:0]  f_hdr;
        logic [63:0] f_data;

        vecs[0] = '{2'b01, 64'h0123_4567_89AB_CDEF, 64'h048D_159E_26AF_37BD, 32'h26AF_37BD, 32'h048D_159E};
        vecs[1] = '{2'b10, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0002, 32'h0000_0002, 32'h0000_0000};
        vecs[2] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
        vecs[3] = '{2'b10, 64'h8000_0000_0000_0001, 64'h0000_0000_0000_0006, 32'h0000_0006, 32'h0000_0000};

        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; s_valid[k] = 1'b0; s_hdr[k] = 2'b00; s_data[k] = '0;
        end
        do_reset();

        // Directed vectors: single block after reset, word layout two cycles later.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            for (int k = 0; k < 2; k++) begin
                s_hdr[k] = vecs[v].hdr; s_data[k] = vecs[v].data; s_valid[k] = 1'b1;
            end
            cycle();
            s_valid[0] = 1'b0; s_valid[1] = 1'b0;
            cycle();
            chk("vec_word64", 0, tx64, vecs[v].exp64);
            chk("vec_word32_lo", 1, {32'd0, tx32}, {32'd0, vecs[v].exp32_lo});
            cycle();
            chk("vec_word32_hi", 1, {32'd0, tx32}, {32'd0, vecs[v].exp32_hi});
        end

        // Continuous source for 330 cycles on both widths.
        do_reset();
        txs[0].delete(); txs[1].delete(); rxs[0].delete(); rxs[1].delete();
        rec_on = 1'b1;
        low64 = 0; adj = 0; acc32 = 0; uf_seen = 0; prev_low = 1'b0;
        for (int c = 0; c < 330; c++) begin
            src_next(0, 1'b1); src_next(1, 1'b1);
            cycle();
            if (!act_rdy[0]) begin
                low64++;
                if (prev_low) adj++;
            end
            prev_low = !act_rdy[0];
            if (act_rdy[1] && s_valid[1]) acc32++;
            uf_seen += int'(uf64) + int'(uf32);
        end
        rec_on = 1'b0;
        chk("ready_low_count", 0, 64'(low64), 64'd10);
        chk("ready_low_adjacent", 0, 64'(adj), 64'd0);
        chk("accepts_330", 1, 64'(acc32), 64'd160);
        chk("underflow_continuous", 0, 64'(uf_seen), 64'd0);
        for (int k = 0; k < 2; k++) begin
            mism = 0;
            for (int i = 0; i < rxs[k].size(); i++) begin
                if (i >= txs[k].size() || rxs[k][i] != txs[k][i]) mism++;
            end
            chk("recon_bits", k, 64'(mism), 64'd0);
            chk("recon_len", k, 64'(rxs[k].size()), 64'(329 * dw[k]));
        end

        // Block held through a ready-low cycle is consumed exactly once.
        do_reset();
        guard = 0;
        while (mq[0].size() < 128 && guard < 64) begin
            src_next(0, 1'b1); src_next(1, 1'b0);
            cycle();
            guard++;
        end
        if (guard >= 64) fail_now("reach_full");
        f_hdr = 2'b10; f_data = 64'hDEAD_BEEF_CAFE_F00D;
        s_hdr[0] = f_hdr; s_data[0] = f_data; s_valid[0] = 1'b1;
        nacc = 0;
        for (int c = 0; c < 2; c++) begin
            cycle();
            if (act_rdy[0]) nacc++;
        end
        chk("held_ready_pattern", 0, 64'(nacc), 64'd1);
        s_valid[0] = 1'b0;
        cycle();
        chk("held_word", 0, tx64, {f_data[61:0], f_hdr});
        cycle();
        chk("held_tail", 0, tx64, {62'd0, f_data[63:62]});
        chk("held_tail_uf", 0, 64'(uf64), 64'd1);

        // One-cycle valid gap while primed: a single padded underflow word.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            src_next(0, 1'b1); src_next(1, 1'b1);
            cycle();
        end
        s_valid[0] = 1'b0;
        cycle();
        n_uf = 0;
        for (int c = 0; c < 10; c++) begin
            src_next(0, 1'b1); src_next(1, 1'b1);
            cycle();
            if (uf64) begin
                n_uf++;
                chk("pad_zero", 0, tx64 >> 20, 64'd0);
            end
        end
        chk("gap_uf_pulses", 0, 64'(n_uf), 64'd1);
        chk("gap_uf_cnt", 0, 64'(cnt64), 64'd1);

        // Reset mid-stream at fill 100.
        do_reset();
        guard = 0;
        while (mq[0].size() != 100 && guard < 200) begin
            src_next(0, 1'b1); src_next(1, 1'b1);
            cycle();
            guard++;
        end
        if (guard >= 200) fail_now("reach_fill100");
        rst[0] = 1'b1;
        cycle();
        rst[0] = 1'b0;
        s_valid[0] = 1'b0;
        chk("rst_ready", 0, 64'(if64.block_ready), 64'd1);
        chk("rst_tx", 0, tx64, 64'd0);
        chk("rst_cnt", 0, 64'(cnt64), 64'd0);
        uf_seen = 0;
        for (int c = 0; c < 6; c++) begin
            cycle();
            uf_seen += int'(uf64);
        end
        chk("rst_no_uf", 0, 64'(uf_seen), 64'd0);

        // Sparse source on the 32-bit lane saturates its 4-bit counter.
        do_reset();
        for (int c = 0; c < 100; c++) begin
            s_valid[1] = 1'b0;
            if ((c % 4) == 0) begin
                src_next(1, 1'b1);
            end
            src_next(0, 1'b0);
            cycle();
        end
        chk("cnt_saturate", 1, 64'(cnt32), 64'd15);

        // Randomised traffic with occasional resets, checked cycle by cycle against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst[0] = ($urandom_range(0, 199) == 0);
            rst[1] = ($urandom_range(0, 199) == 0);
            src_next(0, $urandom_range(0, 99) < 95);
            src_next(1, $urandom_range(0, 99) < 60);
            cycle();
        end
        rst[0] = 1'b0; rst[1] = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
